fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception entry address.
REQ-003 The block SHALL have parameter IMEM_LO, default 32'h0000_3000, meaning the lowest legal fetch address.
REQ-004 The block SHALL have parameter IMEM_HI, default 32'h0000_6FFC, meaning the highest legal fetch address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on posedge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low; 0 at a posedge resets the block.
REQ-007 The block SHALL have port en, input, 1 bit: 1 = advance; 0 = stall/hold PC.
REQ-008 The block SHALL have port req, input, 1 bit: exception/interrupt taken this cycle.
REQ-009 The block SHALL have port eret_D, input, 1 bit: eret resolved in D.
REQ-010 The block SHALL have port EPC, input, 32 bits: return address for eret.
REQ-011 The block SHALL have port redir_valid, input, 1 bit: branch/jump taken, resolved in D.
REQ-012 The block SHALL have port redir_target, input, 32 bits: target of redir_valid.
REQ-013 The block SHALL have port is_bj_D, input, 1 bit: D-stage instruction is a branch/jump.
REQ-014 The block SHALL have port imem_rdata, input, 32 bits: instruction word at imem_addr, combinational.
REQ-015 The block SHALL have port imem_addr, output, 32 bits: fetch address, equal to PC.
REQ-016 The block SHALL have port PC, output, 32 bits: current fetch PC, registered.
REQ-017 The block SHALL have port instru, output, 32 bits: fetched word, or 0 on fetch exception.
REQ-018 The block SHALL have port ExcCode_F, output, 5 bits: 5'd4 (AdEL) or 0.
REQ-019 The block SHALL have port BD_F, output, 1 bit: the fetched instruction is in a delay slot.

Function
REQ-020 The block SHALL hold a 32-bit PC register, a 32-bit pend_target register and a 1-bit state (IDLE, PEND).
REQ-021 The block SHALL select the next PC at each posedge by this priority: reset, req, eret_D, (en=1 and redir_valid), (en=1 and PEND), en=0, default.
REQ-022 The block SHALL, on req, load PC <= HANDLER_PC and state <= IDLE regardless of en.
REQ-023 The block SHALL, on eret_D (without req), load PC <= EPC and state <= IDLE regardless of en.
REQ-024 The block SHALL, when en=1 and redir_valid, load PC <= redir_target and state <= IDLE.
REQ-025 The block SHALL, when en=1, no redir_valid and state PEND, load PC <= pend_target and state <= IDLE.
REQ-026 The block SHALL, when en=0 and redir_valid, hold PC, load pend_target <= redir_target and state <= PEND, with the latest target overwriting an earlier one.
REQ-027 The block SHALL, when en=0 and no redir_valid, hold PC, state and pend_target.
REQ-028 The block SHALL, in the default case, load PC <= PC + 4 with modulo-2^32 wrap and no flag.
REQ-029 The block SHALL assert a fetch fault when PC[1:0] != 0, or PC < IMEM_LO, or PC > IMEM_HI, using unsigned compares.
REQ-030 The block SHALL, on a fetch fault, drive ExcCode_F = 5'd4 and instru = 0; otherwise ExcCode_F = 0 and instru = imem_rdata.
REQ-031 The block SHALL drive ExcCode_F and instru combinationally from the current PC, with zero latency from the PC register.
REQ-032 The block SHALL drive BD_F = is_bj_D combinationally.
REQ-033 The block SHALL drive imem_addr = PC at all times, including faulting PCs; memory output is discarded by REQ-030.
REQ-034 The block SHALL resolve simultaneous req and redir_valid by taking req and discarding the redirect; simultaneous eret_D and redir_valid take eret_D.
REQ-035 The block SHALL, on a redirect to a misaligned or out-of-range target, load that PC and fault per REQ-029, with no special casing.

Reset
REQ-036 The block SHALL, on reset = 0 at a posedge, set PC <= RESET_PC, state <= IDLE and pend_target <= 0, overriding all other inputs.
REQ-037 The block SHALL, the cycle after reset, present PC = 32'h3000, imem_addr = 32'h3000, ExcCode_F = 0, and BD_F following is_bj_D.
REQ-038 The block SHALL, when reset is asserted mid-PEND, discard the pending redirect.

Verification
REQ-039 Release reset with en=1 and no events for 3 cycles -> PC = 3000, 3004, 3008, 300C.
REQ-040 At PC = 3010 with en=0, pulse redir_valid (target 3100) for 1 cycle, hold en=0 for 2 cycles, then en=1 -> PC holds 3010 while stalled, then becomes 3100, state returns to IDLE.
REQ-041 Drive req=1 together with redir_valid (target 3200) and en=0 -> next PC = 4180 and pending is cleared; with eret_D=1 and EPC=3008 the following cycle -> PC = 3008.
REQ-042 Redirect to 3002 -> ExcCode_F = 4 and instru = 0; redirect to 7000 -> ExcCode_F = 4; at 6FFC -> ExcCode_F = 0.
REQ-043 Hold is_bj_D = 1 -> BD_F = 1 in the same cycle; drive reset = 0 during PEND -> PC = 3000 and a later en=1 does not jump.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing with stall-deferred redirects, exception/eret entry and fetch address fault detection
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req,
    input  logic        eret_D,
    input  logic [31:0] EPC,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        is_bj_D,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] instru,
    output logic [4:0]  ExcCode_F,
    output logic        BD_F
);
    typedef enum logic {IDLE, PEND} state_t;
    state_t      state;
    logic [31:0] pend_target;
    logic        fault;
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC          <= RESET_PC;
            state       <= IDLE;
            pend_target <= '0;
        end else if (req) begin
            PC    <= HANDLER_PC;
            state <= IDLE;
        end else if (eret_D) begin
            PC    <= EPC;
            state <= IDLE;
        end else if (en && redir_valid) begin
            PC    <= redir_target;
            state <= IDLE;
        end else if (en && state == PEND) begin
            PC    <= pend_target;
            state <= IDLE;
        end else if (!en) begin
            if (redir_valid) begin
                pend_target <= redir_target;
                state       <= PEND;
            end
        end else begin
            PC <= PC + 32'd4;
        end
    end
    assign fault     = (PC[1:0] != 2'b00) || (PC < IMEM_LO) || (PC > IMEM_HI);
    assign imem_addr = PC;
    assign ExcCode_F = fault ? 5'd4 : 5'd0;
    assign instru    = fault ? 32'd0 : imem_rdata;
    assign BD_F      = is_bj_D;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenario tests for fetch_stage with hand-computed expectations
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, en, req, eret_D, redir_valid, is_bj_D;
    logic [31:0] EPC, redir_target, imem_rdata, imem_addr, PC, instru;
    logic [4:0]  ExcCode_F;
    logic        BD_F;
    int          checks = 0;
    int          errors = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .eret_D(eret_D), .EPC(EPC),
        .redir_valid(redir_valid), .redir_target(redir_target), .is_bj_D(is_bj_D),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .PC(PC), .instru(instru),
        .ExcCode_F(ExcCode_F), .BD_F(BD_F)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; req = 1'b0; eret_D = 1'b0; EPC = 32'h0;
        redir_valid = 1'b0; redir_target = 32'h0; is_bj_D = 1'b0;
        tick();
        tick();
        checks++; if (PC !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h3000); end
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'h3000); end
        checks++; if (ExcCode_F !== 5'd0) begin errors++; $display("FAIL reset_exc got %0d want 0", ExcCode_F); end
        checks++; if (instru !== 32'hDEAD8EEF) begin errors++; $display("FAIL reset_instru got %h want %h", instru, 32'hDEAD8EEF); end
        checks++; if (BD_F !== 1'b0) begin errors++; $display("FAIL reset_bd got %b want 0", BD_F); end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        tick();
        checks++; if (PC !== 32'h3004) begin errors++; $display("FAIL seq1 got %h want %h", PC, 32'h3004); end
        tick();
        checks++; if (PC !== 32'h3008) begin errors++; $display("FAIL seq2 got %h want %h", PC, 32'h3008); end
        tick();
        checks++; if (PC !== 32'h300C) begin errors++; $display("FAIL seq3 got %h want %h", PC, 32'h300C); end
        tick();
        checks++; if (PC !== 32'h3010) begin errors++; $display("FAIL seq4 got %h want %h", PC, 32'h3010); end
    endtask

    task automatic test_stall_redirect();
        en = 1'b0; redir_valid = 1'b1; redir_target = 32'h3100;
        tick();
        checks++; if (PC !== 32'h3010) begin errors++; $display("FAIL stall0 got %h want %h", PC, 32'h3010); end
        redir_valid = 1'b0; redir_target = 32'h0;
        tick();
        checks++; if (PC !== 32'h3010) begin errors++; $display("FAIL stall1 got %h want %h", PC, 32'h3010); end
        tick();
        checks++; if (PC !== 32'h3010) begin errors++; $display("FAIL stall2 got %h want %h", PC, 32'h3010); end
        en = 1'b1;
        tick();
        checks++; if (PC !== 32'h3100) begin errors++; $display("FAIL pend_jump got %h want %h", PC, 32'h3100); end
        tick();
        checks++; if (PC !== 32'h3104) begin errors++; $display("FAIL pend_idle got %h want %h", PC, 32'h3104); end
    endtask

    task automatic test_pend_overwrite();
        en = 1'b0; redir_valid = 1'b1; redir_target = 32'h3200;
        tick();
        redir_target = 32'h3300;
        tick();
        checks++; if (PC !== 32'h3104) begin errors++; $display("FAIL ovw_hold got %h want %h", PC, 32'h3104); end
        redir_valid = 1'b0; en = 1'b1;
        tick();
        checks++; if (PC !== 32'h3300) begin errors++; $display("FAIL ovw_jump got %h want %h", PC, 32'h3300); end
    endtask

    task automatic test_exception();
        en = 1'b0; req = 1'b1; redir_valid = 1'b1; redir_target = 32'h3200;
        tick();
        checks++; if (PC !== 32'h4180) begin errors++; $display("FAIL req_pc got %h want %h", PC, 32'h4180); end
        req = 1'b0; redir_valid = 1'b0; eret_D = 1'b1; EPC = 32'h3008;
        tick();
        checks++; if (PC !== 32'h3008) begin errors++; $display("FAIL eret_pc got %h want %h", PC, 32'h3008); end
        eret_D = 1'b0; en = 1'b1;
        tick();
        checks++; if (PC !== 32'h300C) begin errors++; $display("FAIL req_clr_pend got %h want %h", PC, 32'h300C); end
        eret_D = 1'b1; EPC = 32'h3500; redir_valid = 1'b1; redir_target = 32'h3600;
        tick();
        checks++; if (PC !== 32'h3500) begin errors++; $display("FAIL eret_vs_redir got %h want %h", PC, 32'h3500); end
        eret_D = 1'b0; redir_valid = 1'b0;
    endtask

    task automatic test_fault();
        en = 1'b1; redir_valid = 1'b1; redir_target = 32'h3002;
        tick();
        checks++; if (ExcCode_F !== 5'd4) begin errors++; $display("FAIL mis_exc got %0d want 4", ExcCode_F); end
        checks++; if (instru !== 32'h0) begin errors++; $display("FAIL mis_instru got %h want 0", instru); end
        checks++; if (imem_addr !== 32'h3002) begin errors++; $display("FAIL mis_addr got %h want %h", imem_addr, 32'h3002); end
        redir_target = 32'h7000;
        tick();
        checks++; if (ExcCode_F !== 5'd4) begin errors++; $display("FAIL hi_exc got %0d want 4", ExcCode_F); end
        redir_target = 32'h6FFC;
        tick();
        checks++; if (ExcCode_F !== 5'd0) begin errors++; $display("FAIL top_exc got %0d want 0", ExcCode_F); end
        checks++; if (instru !== 32'hDEADD113) begin errors++; $display("FAIL top_instru got %h want %h", instru, 32'hDEADD113); end
        redir_valid = 1'b0;
        tick();
        checks++; if (PC !== 32'h7000 || ExcCode_F !== 5'd4) begin errors++; $display("FAIL past_top got %h/%0d want 7000/4", PC, ExcCode_F); end
        redir_valid = 1'b1; redir_target = 32'h2FFC;
        tick();
        checks++; if (ExcCode_F !== 5'd4) begin errors++; $display("FAIL lo_exc got %0d want 4", ExcCode_F); end
        redir_target = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        tick();
        checks++; if (PC !== 32'h0 || ExcCode_F !== 5'd4) begin errors++; $display("FAIL wrap got %h/%0d want 0/4", PC, ExcCode_F); end
    endtask

    task automatic test_bd();
        is_bj_D = 1'b1;
        #1;
        checks++; if (BD_F !== 1'b1) begin errors++; $display("FAIL bd_set got %b want 1", BD_F); end
        is_bj_D = 1'b0;
        #1;
        checks++; if (BD_F !== 1'b0) begin errors++; $display("FAIL bd_clr got %b want 0", BD_F); end
    endtask

    task automatic test_reset_pend();
        en = 1'b0; redir_valid = 1'b1; redir_target = 32'h3400;
        tick();
        redir_valid = 1'b0; reset = 1'b0;
        tick();
        checks++; if (PC !== 32'h3000) begin errors++; $display("FAIL rst_pend_pc got %h want %h", PC, 32'h3000); end
        reset = 1'b1; en = 1'b1;
        tick();
        checks++; if (PC !== 32'h3004) begin errors++; $display("FAIL rst_pend_drop got %h want %h", PC, 32'h3004); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_pend_overwrite();
        test_exception();
        test_fault();
        test_bd();
        test_reset_pend();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
